// File: rtl/edsac_word_receiver.sv
`default_nettype none
// ============================================================================
// Module   : edsac_word_receiver
// Purpose  : Recovers 35-bit EDSAC words from the delay-line pulse train.
//            A '1' slot is a burst of pulses, a '0' slot is silent. Slot
//            timing is acquired from the first burst and kept aligned by
//            re-centering the slot counter on early burst edges. Completed
//            words are offered on a valid/ready handshake.
// Ports    : clk_in        system clock (100 MHz)
//            rst_n         asynchronous reset, active-low
//            in_sig        pulse train, asynchronous to clk_in
//            resync        single-cycle: drop lock, clear sticky flags
//            word_data     received word, MSB = first slot
//            word_valid    word_data holds an unconsumed word
//            word_ready    consumer accepts on word_valid && word_ready
//            locked        slot/frame timing acquired
//            framing_error sticky: burst seen in a spacing slot
//            overrun       sticky: word overwritten before acceptance
// Revision : 1.0 - initial release
// ============================================================================
module edsac_word_receiver #(
  parameter int SLOT_CYCLES  = 199,
  parameter int MIN_PULSES   = 4,
  parameter int GUARD_CYCLES = 10,
  parameter int WORD_WIDTH   = 35
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  in_sig,
  input  logic                  resync,
  output logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  locked,
  output logic                  framing_error,
  output logic                  overrun
);

  localparam int c_SLOT_W = $clog2(SLOT_CYCLES);
  localparam int c_EDGE_W = $clog2(MIN_PULSES + 1);
  localparam int c_IDX_W  = $clog2(WORD_WIDTH + 1);

  localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [c_SLOT_W-1:0] c_GUARD     = c_SLOT_W'(GUARD_CYCLES);
  localparam logic [c_SLOT_W-1:0] c_GUARD2    = c_SLOT_W'(2 * GUARD_CYCLES);
  localparam logic [c_EDGE_W-1:0] c_MIN       = c_EDGE_W'(MIN_PULSES);
  localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(WORD_WIDTH - 1);
  localparam logic [c_IDX_W-1:0]  c_IDX_SPACE = c_IDX_W'(WORD_WIDTH);

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_ACQUIRE  = 2'd1,
    S_LOCKED   = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_sync1, r_sync2, r_sync3;
  logic [c_SLOT_W-1:0]   r_slot_cnt;
  logic [c_EDGE_W-1:0]   r_edge_cnt;
  logic [c_IDX_W-1:0]    r_slot_idx;
  logic [WORD_WIDTH-1:0] r_shift;
  logic                  r_load;
  logic [WORD_WIDTH-1:0] r_word;
  logic                  r_valid;
  logic                  r_locked;
  logic                  r_ferr;
  logic                  r_overrun;

  logic                  w_edge;
  logic                  w_slot_end;
  logic                  w_bit;
  logic [c_EDGE_W-1:0]   w_edge_inc;

  // r_sync3 is the previous synchronised sample used for edge detection.
  assign w_edge     = r_sync2 & ~r_sync3;
  assign w_slot_end = (r_slot_cnt == c_SLOT_LAST);
  assign w_bit      = (r_edge_cnt >= c_MIN);
  assign w_edge_inc = (r_edge_cnt >= c_MIN) ? c_MIN : r_edge_cnt + 1'b1;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_UNLOCKED;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_sync3    <= 1'b0;
      r_slot_cnt <= '0;
      r_edge_cnt <= '0;
      r_slot_idx <= '0;
      r_shift    <= '0;
      r_load     <= 1'b0;
      r_word     <= '0;
      r_valid    <= 1'b0;
      r_locked   <= 1'b0;
      r_ferr     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_sync1 <= in_sig;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_load  <= 1'b0;

      // Output handshake. A load in the same cycle as an accept wins and
      // keeps word_valid high without flagging an overrun.
      if (r_valid && word_ready) begin
        r_valid <= 1'b0;
      end
      if (r_load) begin
        r_word  <= r_shift;
        r_valid <= 1'b1;
        if (r_valid && !word_ready) begin
          r_overrun <= 1'b1;
        end
      end

      if (resync) begin
        // Partial word is abandoned; the slot index restarts on reacquire.
        r_state   <= S_UNLOCKED;
        r_locked  <= 1'b0;
        r_ferr    <= 1'b0;
        r_overrun <= 1'b0;
      end else begin
        case (r_state)
          S_UNLOCKED: begin
            if (w_edge) begin
              r_slot_cnt <= c_GUARD;
              r_edge_cnt <= {{(c_EDGE_W-1){1'b0}}, 1'b1};
              r_slot_idx <= '0;
              r_state    <= S_ACQUIRE;
            end
          end

          S_ACQUIRE: begin
            if (w_slot_end) begin
              r_slot_cnt <= '0;
              r_edge_cnt <= '0;
              if (w_bit) begin
                r_shift    <= {r_shift[WORD_WIDTH-2:0], 1'b1};
                r_slot_idx <= {{(c_IDX_W-1){1'b0}}, 1'b1};
                r_state    <= S_LOCKED;
                r_locked   <= 1'b1;
              end else begin
                // Too few pulses: treat as a glitch, no flag.
                r_state <= S_UNLOCKED;
              end
            end else begin
              r_slot_cnt <= r_slot_cnt + 1'b1;
              if (w_edge) begin
                r_edge_cnt <= w_edge_inc;
              end
            end
          end

          S_LOCKED: begin
            // An edge landing exactly on the slot-end cycle is not counted;
            // bursts sit well inside the slot so this costs nothing.
            if (w_slot_end) begin
              r_slot_cnt <= '0;
              r_edge_cnt <= '0;
              if (r_slot_idx == c_IDX_SPACE) begin
                if (w_bit) begin
                  r_ferr   <= 1'b1;
                  r_locked <= 1'b0;
                  r_state  <= S_UNLOCKED;
                end else begin
                  r_slot_idx <= '0;
                end
              end else begin
                r_shift    <= {r_shift[WORD_WIDTH-2:0], w_bit};
                r_slot_idx <= r_slot_idx + 1'b1;
                if (r_slot_idx == c_IDX_LAST) begin
                  r_load <= 1'b1;
                end
              end
            end else if (w_edge) begin
              r_edge_cnt <= w_edge_inc;
              // First edge of a slot inside the early window re-centres the
              // slot counter, absorbing drift in the delay-line pitch.
              if ((r_edge_cnt == '0) && (r_slot_cnt < c_GUARD2)) begin
                r_slot_cnt <= c_GUARD;
              end else begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
              end
            end else begin
              r_slot_cnt <= r_slot_cnt + 1'b1;
            end
          end

          default: begin
            r_state  <= S_UNLOCKED;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign word_data     = r_word;
  assign word_valid    = r_valid;
  assign locked        = r_locked;
  assign framing_error = r_ferr;
  assign overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_edsac_word_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_edsac_word_receiver
// Purpose  : Directed self-checking bench for edsac_word_receiver. Drives
//            modulated pulse bursts at nominal and drifted slot pitch and
//            checks recovered words, lock and the sticky flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edsac_word_receiver;

  localparam int c_W       = 35;
  localparam int c_SLOT_NS = 1990;
  localparam logic [c_W-1:0] c_MASK = 35'h4_9249_2492;

  logic           clk_in;
  logic           rst_n;
  logic           in_sig;
  logic           resync;
  logic [c_W-1:0] word_data;
  logic           word_valid;
  logic           word_ready;
  logic           locked;
  logic           framing_error;
  logic           overrun;

  int n_chk  = 0;
  int n_fail = 0;

  logic [c_W-1:0] exp_q[$];
  logic [c_W-1:0] got_q[$];

  edsac_word_receiver dut (
    .clk_in        (clk_in),
    .rst_n         (rst_n),
    .in_sig        (in_sig),
    .resync        (resync),
    .word_data     (word_data),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .locked        (locked),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Capture every accepted word.
  always @(negedge clk_in) begin
    if (rst_n && word_valid && word_ready) got_q.push_back(word_data);
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic compare_words(input string tag);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk(tag, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic pulse();
    in_sig = 1'b1; #37;
    in_sig = 1'b0; #37;
  endtask

  task automatic send_slot(input logic b, input int pitch);
    if (b) begin
      repeat (12) pulse();
      #(pitch - 888);
    end else begin
      #(pitch);
    end
  endtask

  task automatic send_range(input logic [c_W-1:0] w, input int lo, input int hi, input int pitch);
    for (int i = lo; i <= hi; i++) send_slot(w[c_W-1-i], pitch);
  endtask

  task automatic send_word(input logic [c_W-1:0] w, input logic sp, input int pitch);
    send_range(w, 0, c_W-1, pitch);
    send_slot(sp, pitch);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"},  64'(word_data), 64'h0);
    chk({tag, "_valid"}, 64'(word_valid), 64'h0);
    chk({tag, "_lock"},  64'(locked), 64'h0);
    chk({tag, "_ferr"},  64'(framing_error), 64'h0);
    chk({tag, "_ovr"},   64'(overrun), 64'h0);
  endtask

  initial begin
    logic [63:0]    rnd;
    logic [c_W-1:0] d0, d1;

    rst_n = 1'b0; in_sig = 1'b0; resync = 1'b0; word_ready = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_all_zero("reset");
    @(posedge clk_in); #2; rst_n = 1'b1;
    #200;

    // Short glitch from idle must not lock or produce a word.
    pulse(); pulse();
    #100;
    chk("glitch_acq_lock", 64'(locked), 64'h0);
    #(2 * c_SLOT_NS);
    chk("glitch_lock", 64'(locked), 64'h0);
    chk("glitch_valid", 64'(word_valid), 64'h0);
    compare_words("glitch");

    // All-ones word; lock after the first slot.
    @(posedge clk_in); #2;
    send_slot(1'b1, c_SLOT_NS);
    chk("lock_slot0", 64'(locked), 64'h1);
    send_range(35'h7_FFFF_FFFF, 1, c_W-1, c_SLOT_NS);
    send_slot(1'b0, c_SLOT_NS);
    exp_q.push_back(35'h7_FFFF_FFFF);
    compare_words("ones");
    chk("ones_valid_pulse", 64'(word_valid), 64'h0);
    chk("ones_ferr", 64'(framing_error), 64'h0);
    chk("ones_ovr", 64'(overrun), 64'h0);

    // Alternating pattern followed by an all-zero word with lock held.
    send_word(35'h5_5555_5555, 1'b0, c_SLOT_NS);
    exp_q.push_back(35'h5_5555_5555);
    send_range(35'h0, 0, 17, c_SLOT_NS);
    chk("zero_mid_lock", 64'(locked), 64'h1);
    send_range(35'h0, 18, c_W-1, c_SLOT_NS);
    send_slot(1'b0, c_SLOT_NS);
    exp_q.push_back(35'h0);
    chk("zero_end_lock", 64'(locked), 64'h1);
    compare_words("pat_zero");

    // Drifted pitch, fast then slow.
    rnd = {$urandom(), $urandom()};
    d0  = rnd[c_W-1:0] | c_MASK;
    rnd = {$urandom(), $urandom()};
    d1  = rnd[c_W-1:0] | c_MASK;
    send_word(d0, 1'b0, 1970);
    exp_q.push_back(d0);
    send_word(d1, 1'b0, 2010);
    exp_q.push_back(d1);
    compare_words("drift");
    chk("drift_lock", 64'(locked), 64'h1);

    // Burst in the spacing slot.
    send_word(c_MASK, 1'b1, c_SLOT_NS);
    exp_q.push_back(c_MASK);
    chk("ferr_set", 64'(framing_error), 64'h1);
    chk("ferr_unlock", 64'(locked), 64'h0);
    compare_words("ferr_word");
    @(posedge clk_in); #2; resync = 1'b1;
    @(posedge clk_in); #2; resync = 1'b0;
    @(negedge clk_in);
    chk("resync_ferr", 64'(framing_error), 64'h0);
    chk("resync_lock", 64'(locked), 64'h0);
    #300;
    send_word(35'h5_A5A5_A5A5, 1'b0, c_SLOT_NS);
    exp_q.push_back(35'h5_A5A5_A5A5);
    compare_words("after_resync");
    chk("after_resync_lock", 64'(locked), 64'h1);

    // Overrun: consumer stalled across two words.
    @(posedge clk_in); #2; word_ready = 1'b0;
    send_word(35'h1_2345_6789, 1'b0, c_SLOT_NS);
    send_word(35'h0_0000_00FF, 1'b0, c_SLOT_NS);
    chk("ovr_flag", 64'(overrun), 64'h1);
    chk("ovr_data", 64'(word_data), 64'h0FF);
    chk("ovr_valid", 64'(word_valid), 64'h1);
    @(posedge clk_in); #2; word_ready = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    chk("ovr_valid_clear", 64'(word_valid), 64'h0);
    exp_q.push_back(35'h0_0000_00FF);
    compare_words("ovr");

    // Asynchronous reset in slot 17.
    send_range(35'h7_F0F0_F0F0, 0, 16, c_SLOT_NS);
    repeat (6) pulse();
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (3) @(posedge clk_in);
    #2; rst_n = 1'b1;
    #500;
    send_word(35'h7_0F0F_0F0F, 1'b0, c_SLOT_NS);
    exp_q.push_back(35'h7_0F0F_0F0F);
    compare_words("post_reset");
    chk("post_reset_lock", 64'(locked), 64'h1);
    chk("post_reset_ferr", 64'(framing_error), 64'h0);
    chk("post_reset_ovr", 64'(overrun), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
